// File: rtl/dmem_pipe.sv
// dmem_pipe: single-port MEM-stage data memory with a valid/ready request
// port, byte-lane write enables, a registered read pipeline of configurable
// depth, and a post-reset init sequencer that fills the array.
module dmem_pipe #(
  parameter int BITSIZE      = 32,
  parameter int MEMSIZE      = 64,
  parameter int READ_LATENCY = 1,
  parameter int INIT_MODE    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [$clog2(MEMSIZE)-1:0] req_addr,
  input  logic [BITSIZE-1:0]         req_wdata,
  input  logic [BITSIZE/8-1:0]       req_be,
  output logic                       rsp_valid,
  output logic [BITSIZE-1:0]         rsp_rdata,
  output logic                       init_done
);

  localparam int AW = $clog2(MEMSIZE);
  localparam int NB = BITSIZE / 8;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [AW-1:0]        r_cnt;
  logic [BITSIZE-1:0]   r_mem [MEMSIZE];
  logic [READ_LATENCY-1:0] r_pv;
  logic [BITSIZE-1:0]   r_pd [READ_LATENCY];

  logic                 w_cnt_last;
  logic                 w_init_we;
  logic                 w_accept;
  logic                 w_rd_accept;
  logic                 w_in_range;
  logic [BITSIZE-1:0]   w_init_word;
  logic [BITSIZE-1:0]   w_rd_word;

  assign w_cnt_last  = (r_cnt == AW'(MEMSIZE - 1));
  assign w_in_range  = (int'(req_addr) < MEMSIZE);
  assign w_init_word = (INIT_MODE == 1) ? BITSIZE'(r_cnt) : '0;
  assign w_accept    = req_valid && req_ready;
  assign w_rd_accept = w_accept && !req_write;
  assign w_rd_word   = w_in_range ? r_mem[req_addr] : '0;

  // Next-state and status outputs: INIT sweeps the array, RUN serves requests.
  always_comb begin
    w_state_nxt = r_state;
    w_init_we   = 1'b0;
    req_ready   = 1'b0;
    init_done   = 1'b0;
    case (r_state)
      S_INIT: begin
        w_init_we = 1'b1;
        if (w_cnt_last) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        req_ready = 1'b1;
        init_done = 1'b1;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // State register and init address counter; reset restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_init_we) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Array writes: init pattern during INIT, byte-masked in-range writes in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_init_we) begin
        r_mem[r_cnt] <= w_init_word;
      end else if (w_accept && req_write && w_in_range) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (req_be[b]) begin
            r_mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Read pipeline: data stages only advance behind a valid, so the last
  // stage keeps the previous response while no new one is present.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv <= '0;
      for (int unsigned k = 0; k < READ_LATENCY; k++) begin
        r_pd[k] <= '0;
      end
    end else begin
      r_pv[0] <= w_rd_accept;
      if (w_rd_accept) begin
        r_pd[0] <= w_rd_word;
      end
      for (int unsigned k = 1; k < READ_LATENCY; k++) begin
        r_pv[k] <= r_pv[k-1];
        if (r_pv[k-1]) begin
          r_pd[k] <= r_pd[k-1];
        end
      end
    end
  end

  assign rsp_valid = r_pv[READ_LATENCY-1];
  assign rsp_rdata = r_pd[READ_LATENCY-1];

endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe: drives six dmem_pipe configurations with one shared request
// stream and compares every cycle against a word-array / due-cycle model.
module tb_dmem_pipe;

  localparam int ND = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        rdy [ND];
  logic        rv  [ND];
  logic        dn  [ND];
  logic [31:0] rd  [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    dmem_pipe #(
      .BITSIZE     (32),
      .MEMSIZE     ((g == 4) ? 48 : 64),
      .READ_LATENCY((g < 4) ? (g + 1) : ((g == 4) ? 3 : 2)),
      .INIT_MODE   ((g == 5) ? 0 : 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(rdy[g]),
      .req_write(req_write),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .req_be   (req_be),
      .rsp_valid(rv[g]),
      .rsp_rdata(rd[g]),
      .init_done(dn[g])
    );
  end

  // Reference model: configuration per instance, word arrays, words left to
  // initialise, and a wheel of responses keyed by the edge they appear after.
  int          ms    [ND] = '{64, 64, 64, 64, 48, 64};
  int          lat   [ND] = '{1, 2, 3, 4, 3, 2};
  int          imode [ND] = '{1, 1, 1, 1, 1, 0};
  logic [31:0] mm    [ND][64];
  int          left  [ND];
  logic        wv    [ND][8];
  logic [31:0] wd    [ND][8];
  logic [31:0] exp_rd  [ND];
  logic [31:0] last_rd [ND];
  int          nrsp    [ND];
  logic [31:0] obs0 [$];

  int edge_n = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic        ev;
    logic [31:0] w;
    int          s;
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        left[d] = ms[d];
        for (int k = 0; k < 8; k++) wv[d][k] = 1'b0;
        exp_rd[d] = '0;
      end else if (left[d] > 0) begin
        mm[d][ms[d] - left[d]] = (imode[d] == 1) ? 32'(ms[d] - left[d]) : 32'h0;
        left[d]--;
      end else if (req_valid) begin
        if (req_write) begin
          if (int'(req_addr) < ms[d]) begin
            w = mm[d][req_addr];
            for (int b = 0; b < 4; b++)
              if (req_be[b]) w[8*b +: 8] = req_wdata[8*b +: 8];
            mm[d][req_addr] = w;
          end
        end else begin
          s = (edge_n + lat[d]) % 8;
          wv[d][s] = 1'b1;
          wd[d][s] = (int'(req_addr) < ms[d]) ? mm[d][req_addr] : 32'h0;
        end
      end
    end
    @(posedge clk);
    edge_n++;
    #1;
    for (int d = 0; d < ND; d++) begin
      s  = edge_n % 8;
      ev = wv[d][s];
      if (ev) exp_rd[d] = wd[d][s];
      wv[d][s] = 1'b0;
      checks++;
      assert (rv[d] === ev)
      else begin
        errors++;
        $error("FAIL rsp_valid[%0d] edge %0d: got %b want %b", d, edge_n, rv[d], ev);
      end
      checks++;
      assert (rd[d] === exp_rd[d])
      else begin
        errors++;
        $error("FAIL rsp_rdata[%0d] edge %0d: got %h want %h", d, edge_n, rd[d], exp_rd[d]);
      end
      checks++;
      assert (rdy[d] === (left[d] == 0))
      else begin
        errors++;
        $error("FAIL req_ready[%0d] edge %0d: got %b want %b", d, edge_n, rdy[d], (left[d] == 0));
      end
      checks++;
      assert (dn[d] === (left[d] == 0))
      else begin
        errors++;
        $error("FAIL init_done[%0d] edge %0d: got %b want %b", d, edge_n, dn[d], (left[d] == 0));
      end
      if (rv[d] === 1'b1) begin
        last_rd[d] = rd[d];
        nrsp[d]++;
        if (d == 0) obs0.push_back(rd[d]);
      end
    end
  endtask

  task automatic rd_req(input logic [5:0] a);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wr_req(input logic [5:0] a, input logic [31:0] data, input logic [3:0] be);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_wdata = data;
    req_be    = be;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int n;
    int b2;
    int b3;
    int b4;
    for (int d = 0; d < ND; d++) nrsp[d] = 0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) tick();

    // Init: ready rises after exactly MEMSIZE released edges.
    rst = 1'b0;
    n = 0;
    while (rdy[0] !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (n == 47) chk("ready_ms48_at47", 32'(rdy[4]), 32'h0);
      if (n == 48) chk("ready_ms48_at48", 32'(rdy[4]), 32'h1);
    end
    chk("init_edges", 32'(n), 32'd64);

    // Init pattern readback.
    obs0.delete();
    rd_req(6'd0); rd_req(6'd5); rd_req(6'd63);
    idle(5);
    chk("init_rd_count", 32'(obs0.size()), 32'd3);
    chk("init_rd_0", obs0[0], 32'h0);
    chk("init_rd_5", obs0[1], 32'h5);
    chk("init_rd_63", obs0[2], 32'h3F);

    // Byte enables, including an all-zero mask.
    obs0.delete();
    wr_req(6'd3, 32'hAABBCCDD, 4'b1111);
    wr_req(6'd3, 32'h11223344, 4'b0101);
    rd_req(6'd3);
    wr_req(6'd3, 32'hFFFFFFFF, 4'b0000);
    rd_req(6'd3);
    idle(5);
    chk("be_count", 32'(obs0.size()), 32'd2);
    chk("be_merge", obs0[0], 32'hAA22CC44);
    chk("be_zero", obs0[1], 32'hAA22CC44);

    // Latency sweep: back-to-back reads, timing checked per cycle by the model.
    b3 = nrsp[3];
    rd_req(6'd1); rd_req(6'd2); rd_req(6'd3);
    idle(6);
    chk("lat4_count", 32'(nrsp[3] - b3), 32'd3);
    chk("lat4_last", last_rd[3], 32'hAA22CC44);

    // Read immediately after write.
    obs0.delete();
    wr_req(6'd10, 32'hDEADBEEF, 4'b1111);
    rd_req(6'd10);
    idle(5);
    chk("raw_l1", obs0[0], 32'hDEADBEEF);
    chk("raw_l4", last_rd[3], 32'hDEADBEEF);

    // Out of range on the 48-word instance.
    b4 = nrsp[4];
    wr_req(6'd50, 32'h12345678, 4'b1111);
    rd_req(6'd50);
    idle(5);
    chk("oor_count", 32'(nrsp[4] - b4), 32'd1);
    chk("oor_data", last_rd[4], 32'h0);
    chk("inrange_64", last_rd[0], 32'h12345678);
    for (int a = 0; a < 48; a++) rd_req(6'(a));
    idle(5);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 6'($urandom_range(0, 63));
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      tick();
    end
    idle(6);

    // Reset with reads in flight, then a reset in the middle of init.
    b2 = nrsp[2];
    b4 = nrsp[4];
    rd_req(6'd10);
    rd_req(6'd11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (rdy[0] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("reinit_edges", 32'(n), 32'd64);
    chk("flush_l3", 32'(nrsp[2] - b2), 32'd0);
    chk("flush_ms48", 32'(nrsp[4] - b4), 32'd0);
    obs0.delete();
    rd_req(6'd10);
    idle(4);
    chk("reinit_rd10", obs0[0], 32'hA);
    chk("reinit_rd10_ms48", last_rd[4], 32'hA);
    chk("reinit_rd10_mode0", last_rd[5], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
